// File: rtl/lsu_pkg.sv
// Shared constants and the FSM state type for the load/store unit.
package lsu_pkg;

    localparam int LSU_ADDR_W    = 8;
    localparam int LSU_DATA_W    = 8;
    localparam int LSU_MEM_DEPTH = 192;
    localparam int LSU_COUNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/data_memory.sv
// Single-port data memory: synchronous write, registered read (one edge of latency).
module data_memory #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enable,
    output logic [DATA_W-1:0] read_data
);

    logic [DATA_W-1:0] lines [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            lines[data_address] <= write_data;
        end
        read_data <= lines[data_address];
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, sequences data_memory's registered read,
// faults out-of-range addresses and holds each response until the core takes it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = LSU_MEM_DEPTH,
    parameter int ADDR_W    = LSU_ADDR_W,
    parameter int DATA_W    = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [7:0]        fault_count,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    lsu_state_t        state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              write_q;
    logic              fault_q;
    logic              accept;
    logic              addr_fault;

    assign addr_fault = ({1'b0, req_addr} >= DEPTH_LIMIT);
    assign accept     = req_valid & req_ready;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = addr_fault ? RESP : ACCESS;
            ACCESS:  next_state = write_q ? RESP : CAPTURE;
            CAPTURE: next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            fault_count <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
                fault_q <= addr_fault;
                if (addr_fault && fault_count != 8'hFF) begin
                    fault_count <= fault_count + 8'd1;
                end
            end
            if (state == CAPTURE) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    // Faults never reach ACCESS; the extra terms keep the write strobe dead under reset.
    assign mem_write_enable = (state == ACCESS) & write_q & ~fault_q & ~reset;
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;

    assign req_ready = (state == IDLE) & ~reset;
    assign rsp_valid = (state == RESP) & ~reset;
    assign rsp_fault = (state == RESP) & fault_q;
    assign rsp_rdata = ((state == RESP) && !write_q && !fault_q) ? rdata_q : '0;

endmodule
